nline_prefetch_buffer: RTL and testbench

//  Next-N-line prefetch buffer for the direct-mapped L1 (address/tag-only, no data).
//  - Sits beside the L1 controller and looks up every L1 miss in a fully associative buffer.
//  - On a lookup it issues up to DEGREE sequential line prefetch requests over a valid/ready handshake.
//  - Successor to the single-line prefetcher: parametrised depth and degree, duplicate filtering,

---
 rtl/nline_prefetch_buffer_if.sv | 27 ++
 rtl/nline_prefetch_buffer.sv | 172 +++++++++++++++++
 tb/tb_nline_prefetch_buffer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/nline_prefetch_buffer_if.sv
// Miss/prefetch bus between the L1 controller, the prefetch buffer and memory.
// slave = prefetch buffer side, master = L1 controller / memory side.
interface nline_prefetch_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int OCC_W  = 4
);
  logic              cache_miss;
  logic [ADDR_W-1:0] access_addr;
  logic              flush;
  logic              busy;
  logic              prefetch_hit;
  logic              prefetch_miss;
  logic              pf_req_valid;
  logic [ADDR_W-1:0] pf_req_addr;
  logic              pf_req_ready;
  logic [OCC_W-1:0]  occupancy;

  modport slave (
    input  cache_miss, access_addr, flush, pf_req_ready,
    output busy, prefetch_hit, prefetch_miss, pf_req_valid, pf_req_addr, occupancy
  );

  modport master (
    output cache_miss, access_addr, flush, pf_req_ready,
    input  busy, prefetch_hit, prefetch_miss, pf_req_valid, pf_req_addr, occupancy
  );
endinterface

// File: rtl/nline_prefetch_buffer.sv
// Next-N-line prefetch buffer: fully associative line-tag store looked up on
// every L1 miss, issuing up to DEGREE sequential line prefetches.
module nline_prefetch_buffer #(
  parameter int ADDR_W          = 32,
  parameter int BLOCK_SIZE_BYTE = 16,
  parameter int ENTRIES         = 8,
  parameter int DEGREE          = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  nline_prefetch_buffer_if.slave bus
);
  localparam int OFF = $clog2(BLOCK_SIZE_BYTE);
  localparam int LW  = ADDR_W - OFF;
  localparam int IW  = $clog2(ENTRIES);
  localparam int OW  = IW + 1;
  localparam int DW  = $clog2(DEGREE + 2);  // must hold DEGREE+1

  typedef enum logic [1:0] {IDLE, LOOKUP, ISSUE} state_t;

  state_t                      r_state, w_state_nx;
  logic [ENTRIES-1:0]          r_valid;
  logic [ENTRIES-1:0][LW-1:0]  r_line;
  logic [IW-1:0]               r_vptr;
  logic [LW-1:0]               r_L;
  logic [DW-1:0]               r_d, w_d_nx;
  logic                        r_req_valid;
  logic [LW-1:0]               r_req_line;
  logic                        r_hit, r_miss;
  logic [OW-1:0]               r_occ;

  logic [ENTRIES-1:0]          w_lk_match, w_cand_match, w_valid_eval;
  logic                        w_lk_hit, w_cand_hit, w_hs, w_full, w_done;
  logic [IW-1:0]               w_free_idx, w_ins_idx;
  logic [DW-1:0]               w_d_eval, w_d_inc;
  logic [LW-1:0]               w_cand;
  logic [OW-1:0]               w_cnt;
  logic                        w_ins, w_inval, w_req_set, w_req_clr, w_p_hit, w_p_miss;

  assign w_hs   = r_req_valid && bus.pf_req_ready;
  assign w_full = &r_valid;

  // lowest-index invalid slot
  always_comb begin
    w_free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (!r_valid[i]) w_free_idx = IW'(i);
  end

  assign w_ins_idx = w_full ? r_vptr : w_free_idx;

  // On a handshake edge the next candidate is judged against the buffer as it
  // will be after the insert, so the slot being overwritten no longer counts.
  // The freshly inserted line is L+d and can never equal L+d+1.
  assign w_valid_eval = w_hs ? (r_valid & ~(ENTRIES'(1) << w_ins_idx)) : r_valid;
  assign w_d_eval     = w_hs ? (r_d + DW'(1)) : r_d;
  assign w_d_inc      = w_d_eval + DW'(1);
  assign w_cand       = r_L + LW'(w_d_eval);  // wraps modulo 2^LW
  assign w_done       = w_d_eval > DW'(DEGREE);

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
    assign w_lk_match[g]   = r_valid[g] && (r_line[g] == r_L);
    assign w_cand_match[g] = w_valid_eval[g] && (r_line[g] == w_cand);
  end

  assign w_lk_hit   = |w_lk_match;
  assign w_cand_hit = |w_cand_match;

  // valid-entry count, registered into r_occ
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < ENTRIES; i++) w_cnt = w_cnt + OW'(r_valid[i]);
  end

  // next state and per-cycle control; flush overrides everything
  always_comb begin
    w_state_nx = r_state;
    w_d_nx     = r_d;
    w_ins      = 1'b0;
    w_inval    = 1'b0;
    w_req_set  = 1'b0;
    w_req_clr  = 1'b0;
    w_p_hit    = 1'b0;
    w_p_miss   = 1'b0;
    case (r_state)
      IDLE: if (bus.cache_miss) w_state_nx = LOOKUP;
      LOOKUP: begin
        w_p_hit    = w_lk_hit;
        w_p_miss   = !w_lk_hit;
        w_inval    = w_lk_hit;
        w_d_nx     = DW'(1);
        w_state_nx = ISSUE;
      end
      ISSUE: if (!r_req_valid || bus.pf_req_ready) begin
        w_ins     = w_hs;
        w_req_clr = 1'b1;
        if (w_done) begin
          w_d_nx     = w_d_eval;
          w_state_nx = IDLE;
        end else if (w_cand_hit) begin
          // already buffered: burn one cycle, no request
          w_d_nx = w_d_inc;
          if (w_d_inc > DW'(DEGREE)) w_state_nx = IDLE;
        end else begin
          w_req_set = 1'b1;
          w_req_clr = 1'b0;
          w_d_nx    = w_d_eval;
        end
      end
      default: w_state_nx = IDLE;
    endcase
    if (bus.flush) begin
      w_state_nx = IDLE;
      w_ins      = 1'b0;
      w_inval    = 1'b0;
      w_req_set  = 1'b0;
      w_req_clr  = 1'b1;
      w_p_hit    = 1'b0;
      w_p_miss   = 1'b0;
    end
  end

  // state, entry store, victim pointer, request and pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_valid     <= '0;
      r_line      <= '0;
      r_vptr      <= '0;
      r_L         <= '0;
      r_d         <= '0;
      r_req_valid <= 1'b0;
      r_req_line  <= '0;
      r_hit       <= 1'b0;
      r_miss      <= 1'b0;
      r_occ       <= '0;
    end else begin
      r_state <= w_state_nx;
      r_d     <= w_d_nx;
      r_hit   <= w_p_hit;
      r_miss  <= w_p_miss;
      if (r_state == IDLE && bus.cache_miss && !bus.flush)
        r_L <= bus.access_addr[ADDR_W-1:OFF];
      if (bus.flush) begin
        r_valid <= '0;
        r_vptr  <= '0;
        r_occ   <= '0;
      end else begin
        r_occ <= w_cnt;
        if (w_inval) r_valid <= r_valid & ~w_lk_match;
        if (w_ins) begin
          r_valid[w_ins_idx] <= 1'b1;
          r_line[w_ins_idx]  <= r_req_line;
          if (w_full) r_vptr <= r_vptr + IW'(1);
        end
      end
      if (w_req_set) begin
        r_req_valid <= 1'b1;
        r_req_line  <= w_cand;
      end else if (w_req_clr) begin
        r_req_valid <= 1'b0;
      end
    end
  end

  assign bus.busy          = (r_state != IDLE);
  assign bus.prefetch_hit  = r_hit;
  assign bus.prefetch_miss = r_miss;
  assign bus.pf_req_valid  = r_req_valid;
  assign bus.pf_req_addr   = ADDR_W'(r_req_line) << OFF;
  assign bus.occupancy     = r_occ;
endmodule

// File: tb/tb_nline_prefetch_buffer.sv
// Directed bench for nline_prefetch_buffer (ENTRIES=8, DEGREE=2, 16-byte lines).
module tb_nline_prefetch_buffer;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  nline_prefetch_buffer_if #(.ADDR_W(32), .OCC_W(4)) bus ();

  nline_prefetch_buffer #(
    .ADDR_W(32), .BLOCK_SIZE_BYTE(16), .ENTRIES(8), .DEGREE(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    bus.cache_miss   = 1'b0;
    bus.access_addr  = '0;
    bus.flush        = 1'b0;
    bus.pf_req_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // issue one miss and follow it until busy drops; k counts samples after the capture edge
  task automatic run_miss(input logic [31:0] a, output int hits, output int misses,
                          output int nreq, output logic [31:0] r0, output logic [31:0] r1,
                          output int first_c, output int idle_c, output bit ok);
    hits = 0; misses = 0; nreq = 0; r0 = '1; r1 = '1; first_c = -1; idle_c = -1; ok = 0;
    bus.access_addr = a;
    bus.cache_miss  = 1'b1;
    tick();
    bus.cache_miss  = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.prefetch_hit)  hits++;
      if (bus.prefetch_miss) misses++;
      if (bus.pf_req_valid && bus.pf_req_ready) begin
        if (nreq == 0) begin first_c = k; r0 = bus.pf_req_addr; end
        if (nreq == 1) r1 = bus.pf_req_addr;
        nreq++;
      end
      if (!bus.busy) begin idle_c = k; ok = 1; break; end
      tick();
    end
  endtask

  // start a miss and wait (bounded) for the first request to appear
  task automatic start_and_wait_req(input logic [31:0] a, output bit ok);
    ok = 0;
    bus.access_addr = a;
    bus.cache_miss  = 1'b1;
    tick();
    bus.cache_miss  = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.pf_req_valid) begin ok = 1; break; end
      tick();
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.cache_miss = 1'b0; bus.access_addr = '0; bus.flush = 1'b0; bus.pf_req_ready = 1'b1;
    #3;
    n_cmp++;
    if ({bus.busy, bus.prefetch_hit, bus.prefetch_miss, bus.pf_req_valid, bus.pf_req_addr, bus.occupancy} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got busy=%b hit=%b miss=%b v=%b addr=%h occ=%0d, want all 0",
               bus.busy, bus.prefetch_hit, bus.prefetch_miss, bus.pf_req_valid, bus.pf_req_addr, bus.occupancy);
    end
    do_reset();
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.occupancy !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_release: got busy=%b occ=%0d, want 0/0", bus.busy, bus.occupancy);
    end
  endtask

  task automatic test_basic_miss;
    int h, m, n, fc, ic; logic [31:0] a0, a1; bit ok;
    run_miss(32'h1000, h, m, n, a0, a1, fc, ic, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_timeout: busy never dropped"); end
    n_cmp++; if (m !== 1 || h !== 0) begin n_bad++; $display("FAIL basic_pulse: got hit=%0d miss=%0d, want 0/1", h, m); end
    n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL basic_nreq: got %0d, want 2", n); end
    n_cmp++; if (a0 !== 32'h1010 || a1 !== 32'h1020) begin n_bad++; $display("FAIL basic_addr: got %h %h, want 00001010 00001020", a0, a1); end
    n_cmp++; if (fc !== 2) begin n_bad++; $display("FAIL basic_latency: got %0d, want 2", fc); end
    n_cmp++; if (ic !== 4) begin n_bad++; $display("FAIL basic_busy_len: got %0d, want 4", ic); end
    tick();
    n_cmp++; if (bus.occupancy !== 4'd2) begin n_bad++; $display("FAIL basic_occ: got %0d, want 2", bus.occupancy); end
  endtask

  task automatic test_hit_skip;
    int h, m, n, fc, ic; logic [31:0] a0, a1; bit ok;
    run_miss(32'h1014, h, m, n, a0, a1, fc, ic, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL hit_timeout: busy never dropped"); end
    n_cmp++; if (h !== 1 || m !== 0) begin n_bad++; $display("FAIL hit_pulse: got hit=%0d miss=%0d, want 1/0", h, m); end
    n_cmp++; if (n !== 1 || a0 !== 32'h1030) begin n_bad++; $display("FAIL hit_skip: got n=%0d addr=%h, want 1 00001030", n, a0); end
    n_cmp++; if (fc !== 3) begin n_bad++; $display("FAIL hit_skip_cycle: got %0d, want 3", fc); end
    tick();
    n_cmp++; if (bus.occupancy !== 4'd2) begin n_bad++; $display("FAIL hit_occ: got %0d, want 2", bus.occupancy); end
  endtask

  task automatic test_backpressure;
    bit ok;
    do_reset();
    bus.pf_req_ready = 1'b0;
    start_and_wait_req(32'h5000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_timeout: no request"); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (bus.pf_req_valid !== 1'b1 || bus.pf_req_addr !== 32'h5010 || bus.occupancy !== 4'd0) begin
        n_bad++;
        $display("FAIL bp_hold: cycle %0d got v=%b addr=%h occ=%0d, want 1 00005010 0",
                 k, bus.pf_req_valid, bus.pf_req_addr, bus.occupancy);
      end
      tick();
    end
    bus.pf_req_ready = 1'b1;
    tick();
    n_cmp++;
    if (bus.pf_req_valid !== 1'b1 || bus.pf_req_addr !== 32'h5020) begin
      n_bad++; $display("FAIL bp_next: got v=%b addr=%h, want 1 00005020", bus.pf_req_valid, bus.pf_req_addr);
    end
    tick();
    tick();
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.occupancy !== 4'd2) begin
      n_bad++; $display("FAIL bp_done: got busy=%b occ=%0d, want 0 2", bus.busy, bus.occupancy);
    end
  endtask

  task automatic test_victim;
    int h, m, n, fc, ic; logic [31:0] a0, a1; bit ok;
    do_reset();
    for (int i = 1; i <= 4; i++) run_miss(32'(i) << 12, h, m, n, a0, a1, fc, ic, ok);
    tick();
    n_cmp++; if (bus.occupancy !== 4'd8) begin n_bad++; $display("FAIL victim_fill: got occ=%0d, want 8", bus.occupancy); end
    run_miss(32'h8000, h, m, n, a0, a1, fc, ic, ok);
    n_cmp++;
    if (m !== 1 || n !== 2 || a0 !== 32'h8010 || a1 !== 32'h8020) begin
      n_bad++; $display("FAIL victim_issue: got miss=%0d n=%0d %h %h, want 1 2 00008010 00008020", m, n, a0, a1);
    end
    tick();
    n_cmp++; if (bus.occupancy !== 4'd8) begin n_bad++; $display("FAIL victim_occ: got occ=%0d, want 8", bus.occupancy); end
    // slot 1 (line 0x102) evicted; this miss then evicts slots 2,3
    run_miss(32'h1024, h, m, n, a0, a1, fc, ic, ok);
    n_cmp++; if (m !== 1 || h !== 0) begin n_bad++; $display("FAIL victim_slot1: got hit=%0d miss=%0d, want 0/1", h, m); end
    run_miss(32'h2014, h, m, n, a0, a1, fc, ic, ok);
    n_cmp++; if (m !== 1 || h !== 0) begin n_bad++; $display("FAIL victim_slot2: got hit=%0d miss=%0d, want 0/1", h, m); end
    run_miss(32'h4014, h, m, n, a0, a1, fc, ic, ok);
    n_cmp++; if (h !== 1 || m !== 0) begin n_bad++; $display("FAIL victim_keep: got hit=%0d miss=%0d, want 1/0", h, m); end
  endtask

  task automatic test_wrap;
    int h, m, n, fc, ic; logic [31:0] a0, a1; bit ok;
    do_reset();
    run_miss(32'hFFFF_FFF0, h, m, n, a0, a1, fc, ic, ok);
    n_cmp++;
    if (!ok || n !== 2 || a0 !== 32'h0 || a1 !== 32'h10) begin
      n_bad++; $display("FAIL wrap_addr: got ok=%0d n=%0d %h %h, want 1 2 00000000 00000010", ok, n, a0, a1);
    end
  endtask

  task automatic test_flush_reset;
    int h, m, n, fc, ic; logic [31:0] a0, a1; bit ok;
    do_reset();
    run_miss(32'h7000, h, m, n, a0, a1, fc, ic, ok);
    bus.pf_req_ready = 1'b0;
    start_and_wait_req(32'h6000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL flush_timeout: no request"); end
    bus.pf_req_ready = 1'b1;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    n_cmp++;
    if (bus.pf_req_valid !== 1'b0 || bus.busy !== 1'b0 || bus.occupancy !== 4'd0) begin
      n_bad++; $display("FAIL flush_drop: got v=%b busy=%b occ=%0d, want 0 0 0", bus.pf_req_valid, bus.busy, bus.occupancy);
    end
    tick();
    n_cmp++; if (bus.occupancy !== 4'd0) begin n_bad++; $display("FAIL flush_noinsert: got occ=%0d, want 0", bus.occupancy); end
    // miss together with flush is ignored
    bus.access_addr = 32'h9000; bus.cache_miss = 1'b1; bus.flush = 1'b1;
    tick();
    bus.cache_miss = 1'b0; bus.flush = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL flush_miss_ignored: got busy=%b, want 0", bus.busy); end
    run_miss(32'h7014, h, m, n, a0, a1, fc, ic, ok);
    n_cmp++; if (m !== 1 || h !== 0) begin n_bad++; $display("FAIL flush_forgot: got hit=%0d miss=%0d, want 0/1", h, m); end
    tick();
    bus.pf_req_ready = 1'b0;
    start_and_wait_req(32'hA000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rst_timeout: no request"); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.busy, bus.prefetch_hit, bus.prefetch_miss, bus.pf_req_valid, bus.pf_req_addr, bus.occupancy} !== '0) begin
      n_bad++;
      $display("FAIL rst_async: got busy=%b v=%b addr=%h occ=%0d, want all 0",
               bus.busy, bus.pf_req_valid, bus.pf_req_addr, bus.occupancy);
    end
    tick();
    rst_n = 1'b1;
    bus.pf_req_ready = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_miss();
    test_hit_skip();
    test_backpressure();
    test_victim();
    test_wrap();
    test_flush_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
